spectrum_frame_capture: RTL and testbench
=========================================

SPECTRUM_FRAME_CAPTURE -- requirements
Module: spectrum_frame_capture

Interface
REQ-001 Parameter N, default 8: samples per frame; SHALL be a power of two, 2 to 64.
REQ-002 Parameter W, default 8: sample width in bits, 4 to 16.
REQ-003 Parameter SKIP, default 8: accepted samples discarded after each frame; 0 to 255.
REQ-004 Parameter TWOS, default 0: 1 converts offset-binary ADC codes to two's complement by inverting the MSB.
REQ-005 clk  input  1: single clock; all state changes on its rising edge.
REQ-006 rst  input  1: asynchronous, active-high reset.
REQ-007 sample_valid  input  1: one-cycle strobe; sample_in is valid this cycle.
REQ-008 sample_in  input  W: ADC sample.
REQ-009 freeze  input  1: while high, completed frames are not published.
REQ-010 frame_out  output  N*W: published frame; sample k is in bits [k*W+W-1 : k*W], and sample 0 is the oldest.
REQ-011 frame_valid  output  1: frame_out holds an unconsumed frame.
REQ-012 frame_ready  input  1: downstream FFT accepts the frame when frame_valid and frame_ready are both high.
REQ-013 overrun  output  1: one-cycle pulse when a completed frame is dropped.
REQ-014 overrun_cnt  output  8: saturating count of dropped frames.
REQ-015 busy_fill  output  1: high when the FSM is in FILL.

Function
REQ-016 The block SHALL contain two storage sets: a capture buffer (N x W) and an output register (N*W) driving frame_out.
REQ-017 The FSM SHALL have two states: FILL and DISCARD.
REQ-018 Sample acceptance in FILL: each cycle with sample_valid high stores the conditioned sample at capture index idx, and idx increments.
- idx is log2(N) bits wide and wraps from N-1 to 0.
REQ-019 Sample conditioning: TWOS=1 stores {~sample_in[W-1], sample_in[W-2:0]}; TWOS=0 stores sample_in unchanged.
REQ-020 Frame completion: a sample accepted at idx=N-1 completes the frame; the FSM then goes to DISCARD, or stays in FILL if SKIP=0.
REQ-021 Publish condition: on the completion cycle, the frame is published if freeze is low AND (frame_valid is low OR frame_ready is high).
- The output register loads all N samples, including the sample accepted that same cycle.
- frame_valid is high the next cycle.
REQ-022 Drop on full output: if frame_valid is high and frame_ready is low on the completion cycle, the frame is dropped.
- overrun pulses the next cycle.
- overrun_cnt increments and saturates at 255.
- frame_out and frame_valid are unchanged.
REQ-023 Drop on freeze: if freeze is high on the completion cycle, the frame is discarded silently (no overrun) and capture continues.
REQ-024 Handshake: frame_valid SHALL clear the cycle after frame_valid & frame_ready, unless a publish occurs on that same cycle.
- A same-cycle publish keeps frame_valid high and loads the new data.
REQ-025 While frame_valid is high, frame_out SHALL remain stable.
REQ-026 DISCARD: a counter counts accepted samples_valid strobes up to SKIP; those samples are not stored.
- The strobe that brings the count to SKIP returns the FSM to FILL with idx=0.
REQ-027 Latency: frame_valid rises exactly 1 clk after the completion sample's strobe.
REQ-028 Back-to-back sample_valid on every cycle SHALL be supported without loss in FILL.
REQ-029 sample_valid has no effect on state while rst is high.

Reset
REQ-030 Asserting rst SHALL immediately (asynchronously) force the following, regardless of mid-frame or mid-discard state:
- FSM = FILL, idx = 0, discard counter = 0
- frame_valid = 0, overrun = 0, overrun_cnt = 0
- frame_out = 0, capture buffer = 0
- busy_fill = 1
REQ-031 Deassertion SHALL be treated as synchronous to clk; the first strobe after release is stored at idx=0.

Verification
REQ-032 N=8, W=8, SKIP=8, TWOS=0, frame_ready=1: strobes carry samples 1..8 -> frame_valid high 1 clk after the 8th strobe, frame_out=0x0807060504030201; the next 8 strobes are discarded; the 17th strobe is stored at idx 0.
REQ-033 TWOS=1: sample_in 0x80, 0x00, 0xFF -> stored as 0x00, 0x80, 0x7F.
REQ-034 frame_ready=0, SKIP=0, 3 full frames -> first frame held, overrun pulses twice, overrun_cnt=2, frame_out unchanged; 300 frames -> overrun_cnt=255.
REQ-035 frame_valid=1 with frame_ready asserted on the same cycle as the next completion -> frame_valid stays 1, new data loaded, no overrun.
REQ-036 freeze=1 across a completion -> frame_valid stays 0, overrun stays 0; with freeze=0, the next frame publishes normally.
REQ-037 rst pulse after 5 samples of a frame -> all outputs zero immediately; after release, 8 new strobes publish a frame containing only post-reset samples.

Source files
------------

// File: rtl/spectrum_frame_capture.sv
// spectrum_frame_capture
//   Gathers N consecutive ADC samples into a capture buffer, then publishes the
//   whole frame to an output register for a downstream FFT using a
//   valid/ready handshake. After each completed frame, SKIP accepted samples
//   are thrown away before capture restarts at index 0. A completed frame that
//   finds the output register still occupied is dropped and counted. A frame
//   completed while freeze is high is discarded without being counted.
//
// Ports
//   clk           clock, rising edge
//   rst           asynchronous active-high reset
//   sample_valid  one-cycle strobe qualifying sample_in
//   sample_in     ADC sample, W bits
//   freeze        while high, completed frames are not published
//   frame_out     published frame; sample k at [k*W +: W], sample 0 oldest
//   frame_valid   frame_out holds an unconsumed frame
//   frame_ready   downstream accepts the frame when frame_valid is also high
//   overrun       one-cycle pulse when a completed frame is dropped
//   overrun_cnt   saturating count of dropped frames
//   busy_fill     high while capturing (FILL state)
module spectrum_frame_capture #(
  parameter int unsigned N    = 8,
  parameter int unsigned W    = 8,
  parameter int unsigned SKIP = 8,
  parameter int unsigned TWOS = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           sample_valid,
  input  logic [W-1:0]   sample_in,
  input  logic           freeze,
  output logic [N*W-1:0] frame_out,
  output logic           frame_valid,
  input  logic           frame_ready,
  output logic           overrun,
  output logic [7:0]     overrun_cnt,
  output logic           busy_fill
);

  localparam int unsigned IW = $clog2(N);
  localparam logic [IW-1:0] IdxLast = IW'(N - 1);
  // Only meaningful when SKIP > 0; with SKIP = 0 the DISCARD state is unreachable.
  localparam logic [7:0] SkipLast = 8'(SKIP - 1);

  typedef enum logic {StFill, StDiscard} state_e;

  state_e        state;
  logic [IW-1:0] idx;
  logic [7:0]    skip_cnt;
  logic [W-1:0]  cap [N];

  logic [W-1:0]   cond_sample;
  logic           accept;
  logic           complete;
  logic           publish;
  logic           drop;
  logic [N*W-1:0] full_frame;

  // Offset-binary to two's complement is just an MSB flip.
  assign cond_sample = (TWOS != 0) ? {~sample_in[W-1], sample_in[W-2:0]} : sample_in;

  assign accept   = sample_valid && (state == StFill);
  assign complete = accept && (idx == IdxLast);
  // Freeze wins over the full-output check, so a frozen frame never counts as overrun.
  assign publish  = complete && !freeze && (!frame_valid || frame_ready);
  assign drop     = complete && !freeze && frame_valid && !frame_ready;

  // The completing sample is not yet in the buffer, so splice it into the last lane.
  always_comb begin
    full_frame = '0;
    for (int k = 0; k < int'(N); k++) begin
      if (k == int'(N) - 1) begin
        full_frame[k*W +: W] = cond_sample;
      end else begin
        full_frame[k*W +: W] = cap[k];
      end
    end
  end

  assign busy_fill = (state == StFill);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= StFill;
      idx         <= '0;
      skip_cnt    <= '0;
      frame_out   <= '0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
      overrun_cnt <= '0;
      for (int k = 0; k < int'(N); k++) begin
        cap[k] <= '0;
      end
    end else begin
      overrun <= drop;
      if (drop && (overrun_cnt != 8'hFF)) begin
        overrun_cnt <= overrun_cnt + 8'd1;
      end

      // A same-cycle publish overrides the handshake clear.
      if (publish) begin
        frame_out   <= full_frame;
        frame_valid <= 1'b1;
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end

      unique case (state)
        StFill: begin
          if (sample_valid) begin
            cap[idx] <= cond_sample;
            idx      <= idx + 1'b1;
            if ((idx == IdxLast) && (SKIP != 0)) begin
              state    <= StDiscard;
              skip_cnt <= '0;
            end
          end
        end
        StDiscard: begin
          if (sample_valid) begin
            if (skip_cnt == SkipLast) begin
              state    <= StFill;
              skip_cnt <= '0;
              idx      <= '0;
            end else begin
              skip_cnt <= skip_cnt + 8'd1;
            end
          end
        end
        default: state <= StFill;
      endcase
    end
  end

endmodule

// File: tb/tb_spectrum_frame_capture.sv
// Testbench for spectrum_frame_capture.
//   dut0: N=8 W=8 SKIP=8 TWOS=0  (basic capture, discard, handshake, freeze, reset)
//   dut1: N=8 W=8 SKIP=0 TWOS=1  (sample conditioning, overrun and saturation)
module tb_spectrum_frame_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        sv0 = 1'b0, fz0 = 1'b0, rd0 = 1'b1;
  logic [7:0]  si0 = '0;
  logic [63:0] fo0;
  logic        fv0, ov0, bf0;
  logic [7:0]  oc0;

  logic        sv1 = 1'b0, fz1 = 1'b0, rd1 = 1'b1;
  logic [7:0]  si1 = '0;
  logic [63:0] fo1;
  logic        fv1, ov1, bf1;
  logic [7:0]  oc1;

  int checks = 0;
  int errors = 0;
  int ov_pulses = 0;

  always #5 clk = ~clk;

  spectrum_frame_capture #(.N(8), .W(8), .SKIP(8), .TWOS(0)) dut0 (
    .clk(clk), .rst(rst), .sample_valid(sv0), .sample_in(si0), .freeze(fz0),
    .frame_out(fo0), .frame_valid(fv0), .frame_ready(rd0), .overrun(ov0),
    .overrun_cnt(oc0), .busy_fill(bf0)
  );

  spectrum_frame_capture #(.N(8), .W(8), .SKIP(0), .TWOS(1)) dut1 (
    .clk(clk), .rst(rst), .sample_valid(sv1), .sample_in(si1), .freeze(fz1),
    .frame_out(fo1), .frame_valid(fv1), .frame_ready(rd1), .overrun(ov1),
    .overrun_cnt(oc1), .busy_fill(bf1)
  );

  // Counts overrun pulses of dut1 once per cycle they are high.
  always @(negedge clk) if (ov1 === 1'b1) ov_pulses++;

  typedef struct {
    logic [7:0] din;
    logic [7:0] exp;
  } tw_vec_t;

  tw_vec_t     tv [8];
  logic [63:0] exp_tw;
  int          ov_base;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int sel, input logic [7:0] d);
    if (sel == 0) begin sv0 = 1'b1; si0 = d; end
    else begin sv1 = 1'b1; si1 = d; end
    @(posedge clk); #1;
    sv0 = 1'b0;
    sv1 = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic frame(input int sel, input logic [7:0] base);
    for (int i = 0; i < 8; i++) cyc(sel, base + 8'(i));
  endtask

  task automatic discard(input int n);
    for (int i = 0; i < n; i++) cyc(0, 8'hEE);
  endtask

  function automatic logic [63:0] pack(input logic [7:0] base);
    logic [63:0] r;
    for (int k = 0; k < 8; k++) r[k*8 +: 8] = base + 8'(k);
    return r;
  endfunction

  initial begin
    tv[0] = '{8'h80, 8'h00};
    tv[1] = '{8'h00, 8'h80};
    tv[2] = '{8'hFF, 8'h7F};
    tv[3] = '{8'h7F, 8'hFF};
    tv[4] = '{8'h12, 8'h92};
    tv[5] = '{8'hA5, 8'h25};
    tv[6] = '{8'h01, 8'h81};
    tv[7] = '{8'hFE, 8'h7E};

    // Reset state
    @(posedge clk); #1;
    check("rst frame_valid", fv0, 0);
    check("rst overrun", ov0, 0);
    check("rst overrun_cnt", oc0, 0);
    check("rst frame_out", fo0, 0);
    check("rst busy_fill", bf0, 1);
    @(negedge clk);
    rst = 1'b0;

    // TWOS=1 conditioning, table-driven on dut1
    for (int i = 0; i < 8; i++) begin
      cyc(1, tv[i].din);
      exp_tw[i*8 +: 8] = tv[i].exp;
    end
    check("twos frame_valid", fv1, 1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("twos lane%0d", i), fo1[i*8 +: 8], tv[i].exp);
    end

    // Overrun with frame_ready low, SKIP=0: held frame plus two dropped frames
    rd1 = 1'b0;
    ov_base = ov_pulses;
    frame(1, 8'h01);
    frame(1, 8'h01);
    idle();
    check("ovr pulses", ov_pulses - ov_base, 2);
    check("ovr cnt 2", oc1, 2);
    check("ovr frame held", fo1, exp_tw);
    check("ovr valid held", fv1, 1);
    for (int f = 0; f < 300; f++) frame(1, 8'h40);
    check("ovr cnt saturate", oc1, 255);
    check("ovr frame held sat", fo1, exp_tw);

    // Basic frame on dut0: samples 1..8
    rd0 = 1'b1;
    for (int i = 1; i <= 7; i++) cyc(0, 8'(i));
    check("basic valid before last", fv0, 0);
    check("basic busy_fill", bf0, 1);
    cyc(0, 8'h08);
    check("basic valid latency", fv0, 1);
    check("basic frame_out", fo0, 64'h0807060504030201);
    check("basic in discard", bf0, 0);
    discard(1);
    check("handshake clears valid", fv0, 0);
    discard(6);
    check("still discarding", bf0, 0);
    discard(1);
    check("back to fill", bf0, 1);
    frame(0, 8'h11);
    check("second frame idx0", fo0, pack(8'h11));
    check("second frame valid", fv0, 1);

    // Consume and publish on the same cycle
    rd0 = 1'b0;
    discard(8);
    check("valid held no ready", fv0, 1);
    for (int i = 0; i < 7; i++) cyc(0, 8'h21 + 8'(i));
    check("frame stable while valid", fo0, pack(8'h11));
    rd0 = 1'b1;
    cyc(0, 8'h28);
    check("same-cycle valid", fv0, 1);
    check("same-cycle data", fo0, pack(8'h21));
    check("same-cycle no overrun", ov0, 0);
    idle();
    check("same-cycle then clear", fv0, 0);

    // Freeze across a completion
    discard(8);
    fz0 = 1'b1;
    frame(0, 8'h31);
    check("freeze valid", fv0, 0);
    check("freeze overrun", ov0, 0);
    check("freeze cnt", oc0, 0);
    check("freeze data kept", fo0, pack(8'h21));
    fz0 = 1'b0;
    discard(8);
    frame(0, 8'h41);
    check("unfreeze valid", fv0, 1);
    check("unfreeze data", fo0, pack(8'h41));

    // Drop on full output for dut0
    rd0 = 1'b0;
    discard(8);
    frame(0, 8'h61);
    check("drop overrun pulse", ov0, 1);
    check("drop cnt", oc0, 1);
    check("drop data kept", fo0, pack(8'h41));
    check("drop valid kept", fv0, 1);
    idle();
    check("overrun one cycle", ov0, 0);

    // Asynchronous reset mid-frame
    discard(8);
    for (int i = 0; i < 5; i++) cyc(0, 8'h71 + 8'(i));
    #2 rst = 1'b1;
    #1;
    check("arst frame_valid", fv0, 0);
    check("arst frame_out", fo0, 0);
    check("arst overrun_cnt", oc0, 0);
    check("arst busy_fill", bf0, 1);
    @(negedge clk);
    rst = 1'b0;
    rd0 = 1'b1;
    for (int i = 0; i < 7; i++) cyc(0, 8'h51 + 8'(i));
    check("post-rst not early", fv0, 0);
    cyc(0, 8'h58);
    check("post-rst valid", fv0, 1);
    check("post-rst data", fo0, pack(8'h51));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
